// File: rtl/kof_input_pkg.sv
// rtl/kof_input_pkg.sv - shared action indices, combo states and default HID key bindings
package kof_input_pkg;

  localparam int NUM_ACTIONS = 6;

  localparam int ACT_FWD   = 0;
  localparam int ACT_BACK  = 1;
  localparam int ACT_PUNCH = 2;
  localparam int ACT_SQUAT = 3;
  localparam int ACT_KICK  = 4;
  localparam int ACT_JUMP  = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_DOWN = 2'd1,
    GOT_FWD  = 2'd2
  } combo_state_t;

  // Action 0 sits in the low byte, matching the keymap port layout.
  localparam logic [NUM_ACTIONS*8-1:0] DEFAULT_KEYMAP_P0 =
    {8'h1A, 8'h0E, 8'h16, 8'h0D, 8'h04, 8'h07};
  localparam logic [NUM_ACTIONS*8-1:0] DEFAULT_KEYMAP_P1 =
    {8'h52, 8'h5A, 8'h51, 8'h59, 8'h50, 8'h4F};

endpackage

// File: rtl/kof_combo_fsm.sv
// rtl/kof_combo_fsm.sv - per-player squat -> forward -> punch detector with frame-count window
module kof_combo_fsm
  import kof_input_pkg::*;
#(
  parameter int COMBO_WIN = 12
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic step_i,
  input  logic fwd_i,
  input  logic punch_i,
  input  logic squat_i,
  output logic fire_o
);

  localparam logic [5:0] WIN = 6'(COMBO_WIN);

  combo_state_t state_q, state_d;
  logic [5:0]   cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Advance is checked before restart so one frame moves at most one step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire_o  = 1'b0;
    cnt_inc = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;
    if (step_i) begin
      case (state_q)
        IDLE: begin
          if (squat_i) begin
            state_d = GOT_DOWN;
            cnt_d   = '0;
          end
        end
        GOT_DOWN: begin
          if (fwd_i) begin
            state_d = GOT_FWD;
            cnt_d   = '0;
          end else if (squat_i) begin
            cnt_d = '0;
          end else if (cnt_inc == WIN) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        GOT_FWD: begin
          if (punch_i) begin
            fire_o  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (squat_i) begin
            state_d = GOT_DOWN;
            cnt_d   = '0;
          end else if (cnt_inc == WIN) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/kof_input_mapper.sv
// rtl/kof_input_mapper.sv - frame-synchronous keycode-to-action decoder with per-player combo detect
// Optional macro KOF_INPUT_SOCD_CLEAN_EN neutralises simultaneous forward+back per player.
module kof_input_mapper
  import kof_input_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_KEYCODES = 6,
  parameter int COMBO_WIN    = 12
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frame_clk,
  input  logic [NUM_KEYCODES*8-1:0]            keycodes,
  input  logic [NUM_PLAYERS*NUM_ACTIONS*8-1:0] keymap,
  output logic                                 frame_tick,
  output logic [NUM_PLAYERS*NUM_ACTIONS-1:0]   held,
  output logic [NUM_PLAYERS*NUM_ACTIONS-1:0]   pressed,
  output logic [NUM_PLAYERS-1:0]               combo_fire
);

  localparam int NV = NUM_PLAYERS * NUM_ACTIONS;

  logic [2:0]    sync_q;
  logic          step_q;
  logic [NV-1:0] held_q, pressed_q, match;
  logic [7:0]    key_v;

  assign frame_tick = sync_q[1] & ~sync_q[2];
  assign held       = held_q;
  assign pressed    = pressed_q;

  always_comb begin
    match = '0;
    key_v = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int a = 0; a < NUM_ACTIONS; a++) begin
        key_v = keymap[(p*NUM_ACTIONS+a)*8 +: 8];
        for (int k = 0; k < NUM_KEYCODES; k++) begin
          if (key_v != 8'h00 && keycodes[k*8 +: 8] == key_v) begin
            match[p*NUM_ACTIONS+a] = 1'b1;
          end
        end
      end
    end
`ifdef KOF_INPUT_SOCD_CLEAN_EN
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (match[p*NUM_ACTIONS+ACT_FWD] && match[p*NUM_ACTIONS+ACT_BACK]) begin
        match[p*NUM_ACTIONS+ACT_FWD]  = 1'b0;
        match[p*NUM_ACTIONS+ACT_BACK] = 1'b0;
      end
    end
`endif
  end

  // step_q lags the tick by one cycle so the FSMs see the freshly registered pressed vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      step_q    <= 1'b0;
      held_q    <= '0;
      pressed_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      step_q <= frame_tick;
      if (frame_tick) begin
        held_q    <= match;
        pressed_q <= match & ~held_q;
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_combo
    kof_combo_fsm #(
      .COMBO_WIN(COMBO_WIN)
    ) u_combo_fsm (
      .clk_i   (clk),
      .reset_i (reset),
      .step_i  (step_q),
      .fwd_i   (pressed_q[p*NUM_ACTIONS+ACT_FWD]),
      .punch_i (pressed_q[p*NUM_ACTIONS+ACT_PUNCH]),
      .squat_i (pressed_q[p*NUM_ACTIONS+ACT_SQUAT]),
      .fire_o  (combo_fire[p])
    );
  end

endmodule

// File: tb/tb_kof_input_mapper.sv
// tb/tb_kof_input_mapper.sv - directed self-checking bench for kof_input_mapper
module tb_kof_input_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_clk;
  logic [47:0] keycodes;
  logic [95:0] keymap;
  logic        frame_tick;
  logic [11:0] held;
  logic [11:0] pressed;
  logic [1:0]  combo_fire;

  int vectors     = 0;
  int miscompares = 0;
  int tick_count  = 0;
  int tick_base;

  always #5 clk = ~clk;

  kof_input_mapper #(
    .NUM_PLAYERS  (2),
    .NUM_KEYCODES (6),
    .COMBO_WIN    (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_clk  (frame_clk),
    .keycodes   (keycodes),
    .keymap     (keymap),
    .frame_tick (frame_tick),
    .held       (held),
    .pressed    (pressed),
    .combo_fire (combo_fire)
  );

  always @(negedge clk) if (frame_tick === 1'b1) tick_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: raise frame_clk, wait for the tick, check outputs on the following cycle.
  task automatic do_frame(input string tag, input logic [47:0] kc, input logic [11:0] exp_held,
                          input logic [11:0] exp_pressed, input logic [1:0] exp_fire);
    int waited;
    keycodes  = kc;
    frame_clk = 1'b1;
    waited    = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (frame_tick !== 1'b1 && waited < 8);
    chk({tag, "/tick"}, 32'(frame_tick), 32'd1);
    @(negedge clk);
    chk({tag, "/held"}, 32'(held), 32'(exp_held));
    chk({tag, "/pressed"}, 32'(pressed), 32'(exp_pressed));
    chk({tag, "/fire"}, 32'(combo_fire), 32'(exp_fire));
    @(negedge clk);
    chk({tag, "/fire_end"}, 32'(combo_fire), 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic gap_combo(input string tag, input int gap, input logic [1:0] exp_fire);
    do_frame({tag, "_s"}, 48'h16, 12'h008, 12'h008, 2'b00);
    for (int i = 0; i < gap; i++) do_frame({tag, "_g"}, 48'h0, 12'h000, 12'h000, 2'b00);
    do_frame({tag, "_f"}, 48'h07, 12'h001, 12'h001, 2'b00);
    do_frame({tag, "_p"}, 48'h0D, 12'h004, 12'h004, exp_fire);
    do_frame({tag, "_z"}, 48'h0, 12'h000, 12'h000, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    frame_clk = 1'b0;
    keycodes  = '0;
    keymap    = {8'h52, 8'h5A, 8'h51, 8'h59, 8'h50, 8'h4F,
                 8'h1A, 8'h0E, 8'h16, 8'h0D, 8'h04, 8'h07};
    repeat (3) @(negedge clk);
    chk("rst_held", 32'(held), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_fire", 32'(combo_fire), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tick_count = 0;

    do_frame("idle0", 48'h0, 12'h000, 12'h000, 2'b00);
    do_frame("idle1", 48'h0, 12'h000, 12'h000, 2'b00);
    chk("tick_count2", 32'(tick_count), 32'd2);

    tick_base = tick_count;
    frame_clk = 1'b1;
    repeat (20) @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk("tick_held_high", 32'(tick_count - tick_base), 32'd1);

    do_frame("fwd1", 48'h07, 12'h001, 12'h001, 2'b00);
    do_frame("fwd2", 48'h07, 12'h001, 12'h000, 2'b00);
    do_frame("fwd3", 48'h07, 12'h001, 12'h000, 2'b00);
    chk("fwd_pressed_hold", 32'(pressed), 32'd0);
    do_frame("fwd_rel", 48'h0, 12'h000, 12'h000, 2'b00);

    do_frame("p1c1", 48'h51, 12'h200, 12'h200, 2'b00);
    do_frame("p1c2", 48'h00, 12'h000, 12'h000, 2'b00);
    do_frame("p1c3", 48'h4F, 12'h040, 12'h040, 2'b00);
    do_frame("p1c4", 48'h00, 12'h000, 12'h000, 2'b00);
    do_frame("p1c5", 48'h59_00_00_00_00_00, 12'h100, 12'h100, 2'b10);
    do_frame("p1c6", 48'h00, 12'h000, 12'h000, 2'b00);

    gap_combo("gap12", 12, 2'b00);
    gap_combo("gap11", 11, 2'b01);
    gap_combo("gap5", 5, 2'b01);

`ifdef KOF_INPUT_SOCD_CLEAN_EN
    do_frame("socd", 48'h04_07, 12'h000, 12'h000, 2'b00);
`else
    do_frame("socd", 48'h04_07, 12'h003, 12'h003, 2'b00);
`endif
    do_frame("socd_rel", 48'h0, 12'h000, 12'h000, 2'b00);

    do_frame("rc_s", 48'h16, 12'h008, 12'h008, 2'b00);
    do_frame("rc_f", 48'h07, 12'h001, 12'h001, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_held", 32'(held), 32'd0);
    chk("mid_rst_pressed", 32'(pressed), 32'd0);
    chk("mid_rst_fire", 32'(combo_fire), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_frame("rc_p", 48'h0D, 12'h004, 12'h004, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
